// File: rtl/div20_if.sv
// div20_if: start/done handshake bundle for the sequential divider.
//   start    - request a new division (master -> divider)
//   a, b     - dividend and divisor, captured on an accepted start
//   busy     - division in progress
//   done     - one-cycle completion pulse; q/r/div_zero valid from here
//   q, r     - quotient and remainder, held until the next completion
//   div_zero - last completed division had a zero divisor
interface div20_if #(
  parameter int unsigned WIDTH = 20
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_zero;

  modport master (
    output start, a, b,
    input  busy, done, q, r, div_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, div_zero
  );
endinterface

// File: rtl/div20.sv
// div20: sequential unsigned restoring divider, one quotient bit per cycle.
// Trial subtraction is done as complement-and-add; the carry-out is the
// no-borrow flag that selects the restored or the subtracted remainder.
//   clk - rising-edge clock
//   rst - synchronous active-high reset, aborts any division in flight
//   bus - div20_if slave: start/a/b in, busy/done/q/r/div_zero out
module div20 #(
  parameter int unsigned WIDTH = 20
) (
  input  logic   clk,
  input  logic   rst,
  div20_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             carry;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] dvd_nx;
  logic             unused_trial_msb;

  // The 21-bit partial remainder exists only as the shifted value feeding
  // the adder; after each step it is below b, so its top bit is always zero
  // and the stored copy keeps just the low WIDTH bits.
  assign unused_trial_msb = trial[WIDTH];

  always_comb begin
    rem_sh         = {rem_q, dvd_q[WIDTH-1]};
    {carry, trial} = {1'b0, rem_sh} + {1'b0, ~{1'b0, b_q}} + (WIDTH+2)'(1);
    rem_nx         = carry ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_nx         = {dvd_q[WIDTH-2:0], carry};

    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quo_d   = quo_q;
    res_d   = res_q;
    dz_d    = dz_q;

    case (state_q)
      S_RUN: begin
        rem_d = rem_nx;
        dvd_d = dvd_nx;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          quo_d   = dvd_nx;
          res_d   = rem_nx;
          dz_d    = 1'b0;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (bus.start) begin
          if (bus.b != '0) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            dvd_d   = bus.a;
            rem_d   = '0;
            b_d     = bus.b;
            cnt_d   = '0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            quo_d   = '1;
            res_d   = bus.a;
            dz_d    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      res_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.q        = quo_q;
  assign bus.r        = res_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_div20.sv
module tb_div20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div20_if #(.WIDTH(20)) bus ();

  div20 #(.WIDTH(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          dc;
    logic [19:0] q;
    logic [19:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  int cyc      = 0;
  int free_cyc = 0;
  int bs       = 0;
  int be       = -1;
  int tests    = 0;
  int fails    = 0;

  logic [19:0] held_q  = '0;
  logic [19:0] held_r  = '0;
  logic        held_dz = 1'b0;

  // Reference model: plain arithmetic on operands seen at each clock edge.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      be       = -1;
      free_cyc = cyc + 1;
      held_q   = '0;
      held_r   = '0;
      held_dz  = 1'b0;
    end else if (bus.start && cyc >= free_cyc) begin
      if (bus.b == 20'd0) begin
        e.dc     = cyc + 1;
        e.q      = 20'hFFFFF;
        e.r      = bus.a;
        e.dz     = 1'b1;
        free_cyc = cyc + 1;
      end else begin
        e.dc     = cyc + 21;
        e.q      = bus.a / bus.b;
        e.r      = bus.a % bus.b;
        e.dz     = 1'b0;
        bs       = cyc + 1;
        be       = cyc + 20;
        free_cyc = cyc + 21;
      end
      sb.push_back(e);
    end
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, want);
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      chk("busy", 20'(bus.busy), 20'((cyc >= bs && cyc <= be) ? 1 : 0));
      chk("busy_and_done", 20'(bus.busy & bus.done), 20'd0);
      while (sb.size() > 0 && sb[0].dc < cyc) begin
        tests++;
        fails++;
        $display("FAIL missing_done at cycle %0d: got none expected done at %0d", cyc, sb[0].dc);
        void'(sb.pop_front());
      end
      if (bus.done === 1'b1) begin
        tests++;
        if (sb.size() == 0 || sb[0].dc != cyc) begin
          fails++;
          $display("FAIL spurious_done at cycle %0d: got done expected none", cyc);
        end else begin
          e       = sb.pop_front();
          held_q  = e.q;
          held_r  = e.r;
          held_dz = e.dz;
        end
      end
      chk("q", bus.q, held_q);
      chk("r", bus.r, held_r);
      chk("div_zero", 20'(bus.div_zero), 20'(held_dz));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free();
    int n = 0;
    while (cyc < free_cyc && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      tests++;
      fails++;
      $display("FAIL wait_timeout at cycle %0d: got busy expected free by %0d", cyc, free_cyc);
    end
  endtask

  task automatic op(input logic [19:0] aa, input logic [19:0] bb);
    bus.start = 1'b1;
    bus.a     = aa;
    bus.b     = bb;
    tick();
    bus.start = 1'b0;
    wait_free();
  endtask

  initial begin
    logic [19:0] ra, rb;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    op(20'd100, 20'd7);
    tick();
    op(20'hFFFFF, 20'd1);
    op(20'hFFFFF, 20'hFFFFF);
    op(20'd3, 20'd10);
    op(20'd5, 20'd0);
    op(20'd9, 20'd3);
    tick();

    // start during RUN must be ignored
    bus.start = 1'b1; bus.a = 20'd100; bus.b = 20'd7;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1; bus.a = 20'd50; bus.b = 20'd5;
    tick();
    bus.start = 1'b0;
    wait_free();
    tick();

    // start held high: back-to-back issue from the DONE cycle
    bus.start = 1'b1; bus.a = 20'd1000; bus.b = 20'd10;
    tick();
    wait_free();
    bus.a = 20'd1001;
    tick();
    wait_free();
    bus.start = 1'b0;
    tick();
    tick();

    // reset in the middle of a division
    bus.start = 1'b1; bus.a = 20'd100; bus.b = 20'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    op(20'd77, 20'd8);
    tick();

    for (int i = 0; i < 150; i++) begin
      ra = 20'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 20'd0;
        1, 2:    rb = 20'($urandom_range(1, 15));
        3:       rb = 20'hFFFFF - 20'($urandom_range(0, 3));
        default: rb = 20'($urandom);
      endcase
      op(ra, rb);
      repeat ($urandom_range(0, 2)) tick();
    end

    repeat (25) tick();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div20.md
# div20

Sequential 20-bit unsigned restoring divider for the arithmetic unit. It computes quotient and remainder one bit per cycle by repeated trial subtraction, using complement-and-add with carry-out as the no-borrow flag. It pairs with the 20-bit add/sub datapath: `add20`/`sub` produce results in one combinational pass, while `div20` runs multi-cycle behind a start/done handshake.

## Interface
- `WIDTH`, default 20: operand, quotient and remainder width. Only 20 is verified.
- `clk`, input, 1: single clock. All state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new division. Sampled only when the unit is not busy.
- `a`, input, 20: dividend, captured on an accepted `start`.
- `b`, input, 20: divisor, captured on an accepted `start`.
- `busy`, output, 1: high while a division is in progress.
- `done`, output, 1: one-cycle pulse; `q`, `r` and `div_zero` are valid from this cycle.
- `q`, output, 20: quotient, held until the next completion.
- `r`, output, 20: remainder, held until the next completion.
- `div_zero`, output, 1: the last completed division had `b == 0`. Held until the next completion.

## Operation
- States:
  - IDLE: accepts `start`.
  - RUN: iterates.
  - DONE: lasts one cycle; also accepts `start`.
- Acceptance: `start=1` in IDLE or DONE captures `a` and `b`. `start` in RUN is ignored, and the operands are not re-sampled.
- Accepted `start` with `b != 0`:
  - Go to RUN. Load the dividend shift register with `a`, the 21-bit partial remainder with 0, and the iteration counter with 0.
- Each RUN cycle:
  - Shift: `rem = {rem[19:0], dvd[19]}` and `dvd <<= 1`.
  - Trial: `t = rem + ~{0,b} + 1`, computed at 21 bits plus carry.
  - If carry = 1 (no borrow): `rem = t` and the quotient bit is 1; otherwise `rem` is unchanged and the quotient bit is 0.
  - Quotient bits shift into the LSB of the dividend register.
  - The counter increments; after iteration 19, go to DONE.
- Accepted `start` with `b == 0`:
  - Skip RUN and go directly to DONE.
  - Result: `q = 20'hFFFFF`, `r = a`, `div_zero = 1`.
- DONE:
  - Register `q`, `r[19:0]` and `div_zero`. Assert `done` and deassert `busy`.
  - Next state is IDLE, or RUN/DONE if a new `start` is accepted in the same cycle (back-to-back operation).
- Arithmetic rules:
  - Unsigned only.
  - The partial remainder is 21 bits so that shifting never overflows for `b` up to `20'hFFFFF`.
  - Final `r < b` always, and bit 20 of the remainder is 0 at completion.

## Timing
- Reset values: `busy=0`, `done=0`, `q=0`, `r=0`, `div_zero=0`; state IDLE; counter 0.
- Cycle numbering: `start` accepted in cycle 0.
  - Normal operation: `busy=1` in cycles 1–20 and `done=1` in cycle 21. Latency is 21 cycles, and the next operation may start in cycle 21.
  - Divide by zero: `done=1` in cycle 1 and `busy` stays 0.
- `busy` and `done` are never high in the same cycle.
- `q`, `r` and `div_zero` change only in a DONE cycle. They keep their previous values during RUN.
- Reset mid-operation: `rst` in any cycle forces the reset values on the next edge and aborts the operation. No `done` is produced for it. `rst` overrides a simultaneous `start`.
- `start` held high continuously issues a new division each time the unit reaches DONE, with operands sampled in that DONE cycle.

## Test plan
- `a=100`, `b=7`, start in cycle 0 → `busy` in cycles 1–20; `done` in cycle 21 with `q=14`, `r=2`, `div_zero=0`.
- `a=20'hFFFFF`, `b=1` → `q=20'hFFFFF`, `r=0`. Then `a=20'hFFFFF`, `b=20'hFFFFF` → `q=1`, `r=0`. Then `a=3`, `b=10` → `q=0`, `r=3`.
- `a=5`, `b=0` → `done` in cycle 1, `busy` never high, `q=20'hFFFFF`, `r=5`, `div_zero=1`. A following `a=9`, `b=3` gives `q=3`, `r=0`, `div_zero=0`.
- `a=100`, `b=7` started, then `start` with `a=50`, `b=5` in cycle 5 → ignored; cycle 21 still reports `q=14`, `r=2`.
- Back-to-back: `start` held high with `a=1000`, `b=10`, then `a=1001`, `b=10` presented in cycle 21 → `done` in cycles 21 (`q=100`, `r=0`) and 42 (`q=100`, `r=1`).
- `rst` in cycle 10 of `a=100`, `b=7` → all outputs 0 from cycle 11, no `done`. A new start with `a=77`, `b=8` completes 21 cycles later with `q=9`, `r=5`.
